// File: rtl/arb48_pkg.sv
// arb48_pkg: shared types, constants and the above-pointer mask helper for the 48-way arbiter
package arb48_pkg;
  localparam int NREQ = 48;
  typedef logic [5:0] idx_t;
  typedef logic [47:0] reqv_t;
  localparam idx_t NONE = 6'd63;
  typedef enum logic {IDLE, GRANT} arb_state_e;
  function automatic reqv_t above_mask(input idx_t p);
    reqv_t m;
    for (int i = 0; i < NREQ; i++) m[i] = (i > int'(p));
    return m;
  endfunction
endpackage

// File: rtl/flo48.sv
// flo48: find-lowest-one encoder over 48 bits, returns NONE (63) when empty
module flo48 import arb48_pkg::*; (
  input  logic [NREQ-1:0] vec,
  output idx_t            idx
);
  always_comb begin
    idx = NONE;
    for (int i = NREQ - 1; i >= 0; i--) if (vec[i]) idx = idx_t'(i);
  end
endmodule

// File: rtl/rr_arbiter48.sv
// rr_arbiter48: 48-way round-robin arbiter with locked grants and a dead cycle between owners.
// Define ARB_TIMEOUT_EN to force release after MAX_HOLD grant cycles.
module rr_arbiter48 import arb48_pkg::*; #(
  parameter int MAX_HOLD = 1024
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic [NREQ-1:0] req_i,
  input  logic            rel_i,
  output logic            gnt_vld_o,
  output logic [5:0]      gnt_idx_o,
  output logic [NREQ-1:0] gnt_oh_o,
  output logic            timeout_o
);
  arb_state_e state;
  idx_t ptr, m_idx, r_idx, win;
  logic rel, to;
  flo48 u_flo_m (.vec(req_i & above_mask(ptr)), .idx(m_idx));
  flo48 u_flo_r (.vec(req_i), .idx(r_idx));
  assign win = (m_idx != NONE) ? m_idx : r_idx;
  assign rel = rel_i | ~req_i[gnt_idx_o];
`ifdef ARB_TIMEOUT_EN
  localparam int CW = $clog2(MAX_HOLD) + 1;
  logic [CW-1:0] cnt;
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) cnt <= '0;
    else cnt <= (state == IDLE) ? '0 : cnt + 1'b1;
  // a normal release on the same cycle wins, so timeout only fires when rel is low
  assign to = (state == GRANT) && !rel && (cnt == CW'(MAX_HOLD - 1));
`else
  logic unused_max_hold;
  assign unused_max_hold = ^MAX_HOLD;
  assign to = 1'b0;
`endif
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= IDLE;
      ptr       <= idx_t'(NREQ - 1);
      gnt_vld_o <= 1'b0;
      gnt_idx_o <= NONE;
      gnt_oh_o  <= '0;
      timeout_o <= 1'b0;
    end else begin
      timeout_o <= 1'b0;
      if (state == IDLE) begin
        if (win != NONE) begin
          state     <= GRANT;
          gnt_vld_o <= 1'b1;
          gnt_idx_o <= win;
          gnt_oh_o  <= reqv_t'(1) << win;
        end
      end else if (rel || to) begin
        state     <= IDLE;
        ptr       <= gnt_idx_o;
        gnt_vld_o <= 1'b0;
        gnt_idx_o <= NONE;
        gnt_oh_o  <= '0;
        timeout_o <= to;
      end
    end
  end
endmodule

// File: tb/tb_rr_arbiter48.sv
// tb_rr_arbiter48: scoreboard bench with a round-robin reference model, directed and random stimulus
module tb_rr_arbiter48;
  logic        clk = 0, rst_n = 1, rel = 0;
  logic [47:0] req = '0;
  logic        gnt_vld_o, timeout_o;
  logic [5:0]  gnt_idx_o;
  logic [47:0] gnt_oh_o;
  always #5 clk = ~clk;
`ifdef ARB_TIMEOUT_EN
  localparam int MH = 8;
  rr_arbiter48 #(.MAX_HOLD(MH)) dut (.clk(clk), .rst_n(rst_n), .req_i(req), .rel_i(rel),
    .gnt_vld_o(gnt_vld_o), .gnt_idx_o(gnt_idx_o), .gnt_oh_o(gnt_oh_o), .timeout_o(timeout_o));
`else
  localparam int MH = 0;
  rr_arbiter48 dut (.clk(clk), .rst_n(rst_n), .req_i(req), .rel_i(rel),
    .gnt_vld_o(gnt_vld_o), .gnt_idx_o(gnt_idx_o), .gnt_oh_o(gnt_oh_o), .timeout_o(timeout_o));
`endif
  int compared = 0, mismatched = 0;
  int expq[$], glog[$], gcyc[$];
  int owner = -1, last = 47, held = 0, cyc_n = 0, cur = 0;
  logic pv = 0;
  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    compared++;
    if (act !== exp) begin
      mismatched++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask
  task automatic cyc(input int n);
    repeat (n) @(negedge clk);
  endtask
  task automatic wait_vld();
    int n = 0;
    while (!gnt_vld_o && n < 20) begin cyc(1); n++; end
    chk("wait_vld", {63'd0, gnt_vld_o}, 64'd1);
  endtask
  // reference: next requester after the last owner in circular order; event codes 100/101 = release/timeout
  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      owner = -1; last = 47; expq.delete();
    end else if (owner < 0) begin
      if (req != 0) begin
        for (int k = 1; k <= 48 && owner < 0; k++) if (req[(last + k) % 48]) owner = (last + k) % 48;
        expq.push_back(owner);
        held = 0;
      end
    end else begin
      held++;
      if (rel || !req[owner]) begin expq.push_back(100); last = owner; owner = -1; end
      else if (MH > 0 && held == MH) begin expq.push_back(101); last = owner; owner = -1; end
    end
  end
  always @(posedge clk) cyc_n++;
  always @(negedge clk) begin
    int ev;
    if (!rst_n) pv = 0;
    else begin
      ev = -1;
      if (gnt_vld_o && !pv) begin
        ev = int'(gnt_idx_o); cur = ev;
        glog.push_back(ev); gcyc.push_back(cyc_n);
        chk("onehot", gnt_oh_o, 64'd1 << gnt_idx_o);
      end else if (!gnt_vld_o && pv) begin
        ev = 100 + int'(timeout_o);
        chk("idle_idx", gnt_idx_o, 63);
        chk("idle_oh", gnt_oh_o, 0);
      end else begin
        chk("no_timeout", timeout_o, 0);
        if (gnt_vld_o) chk("hold_idx", gnt_idx_o, cur);
      end
      if (ev >= 0) begin
        if (expq.size() > 0) chk("sb_event", ev, expq.pop_front());
        else begin compared++; mismatched++; $display("FAIL sb_unexpected: got %0d expected none", ev); end
      end
      pv = gnt_vld_o;
    end
  end
  initial begin
    int n;
    #1 rst_n = 0;
    cyc(2);
    chk("rst_vld", gnt_vld_o, 0); chk("rst_idx", gnt_idx_o, 63); chk("rst_oh", gnt_oh_o, 0);
    rst_n = 1; cyc(1);
    req = 48'h1; cyc(1);
    chk("t1_idx", gnt_idx_o, 0); chk("t1_oh", gnt_oh_o, 1); chk("t1_vld", gnt_vld_o, 1);
    req = 0; cyc(3);
    n = glog.size();
    req = (48'd1 << 3) | (48'd1 << 10) | (48'd1 << 47);
    repeat (5) begin wait_vld(); rel = 1; cyc(1); rel = 0; end
    req = 0; cyc(3);
    chk("t2_g0", glog[n], 3); chk("t2_g1", glog[n+1], 10); chk("t2_g2", glog[n+2], 47);
    chk("t2_g3", glog[n+3], 3); chk("t2_g4", glog[n+4], 10);
    for (int i = 0; i < 4; i++) chk("t2_space", gcyc[n+i+1] - gcyc[n+i], 2);
    req = 48'd1 << 5; wait_vld(); chk("t3_own", gnt_idx_o, 5);
    req = 48'd1 << 6; cyc(1); chk("t3_drop", gnt_vld_o, 0);
    cyc(1); chk("t3_next", gnt_idx_o, 6);
    req = 0; cyc(3);
    req = 48'd1 << 47; wait_vld(); chk("t4_own", gnt_idx_o, 47);
    req = (48'd1 << 47) | 48'd1; rel = 1; cyc(1); rel = 0;
    chk("t4_rel", gnt_vld_o, 0); cyc(1); chk("t4_wrap", gnt_idx_o, 0);
    req = 0; cyc(3);
    req = 48'd1 << 20; wait_vld(); chk("t5_own", gnt_idx_o, 20);
    #2 rst_n = 0; #1;
    chk("t5_vld", gnt_vld_o, 0); chk("t5_idx", gnt_idx_o, 63); chk("t5_oh", gnt_oh_o, 0);
    cyc(2); req = (48'd1 << 20) | (48'd1 << 30); rst_n = 1;
    cyc(1); chk("t5_regrant", gnt_idx_o, 20);
    req = 0; cyc(3);
    req = (48'd1 << 9) | (48'd1 << 12); wait_vld(); chk("t6_own", gnt_idx_o, 9);
`ifdef ARB_TIMEOUT_EN
    cyc(7); chk("t6_held", gnt_idx_o, 9);
    cyc(1); chk("t6_drop", gnt_vld_o, 0); chk("t6_to", timeout_o, 1);
    cyc(1); chk("t6_to_clr", timeout_o, 0); chk("t6_next", gnt_idx_o, 12);
`else
    cyc(20); chk("t6_held", gnt_idx_o, 9); chk("t6_vld", gnt_vld_o, 1); chk("t6_to", timeout_o, 0);
`endif
    req = 0; cyc(3);
    repeat (3000) begin
      if ($urandom_range(0, 3) == 0) begin
        req = {$urandom, $urandom} & {$urandom, $urandom} & {$urandom, $urandom};
        if ($urandom_range(0, 7) == 0) req = 0;
        if ($urandom_range(0, 7) == 0) req = {47'd0, 1'b1} << $urandom_range(0, 47);
      end
      rel = ($urandom_range(0, 5) == 0);
      cyc(1);
    end
    req = 0; rel = 0; cyc(4);
    chk("sb_drain", expq.size(), 0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end
endmodule
